mcb_init_sequencer: RTL and testbench



---
 rtl/mcb_init_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_mcb_init_sequencer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mcb_init_sequencer.sv
// mcb_init_sequencer
// ------------------
// Brings up the DDR3 MCB that sits behind the multi-ROI frame buffer.
// 1. Waits for the BUFPLL lock to stay high for LOCK_STABLE_CYCLES consecutive cycles.
// 2. Holds the MCB system reset for RST_HOLD_CYCLES.
// 3. Waits up to CALIB_TIMEOUT cycles for calibration done.
//    On a timeout it re-runs the reset hold, up to MAX_RETRY extra attempts, and then fails.
// The frame-buffer enable stays low until memory is ready.
//
// Optional build macro MCB_LOCK_LOSS_RECOVER_EN:
//   defined   - lock loss while READY re-runs the whole bring-up and clears retry_cnt.
//   undefined - lock loss while READY is a sticky failure.
//
// Ports:
//   clk              sequencer clock (mcb_drp_clk domain)
//   reset            synchronous, active-high reset
//   bufpll_mcb_lock  BUFPLL lock, asynchronous (double-flop synchronized)
//   calib_done       MCB calibration complete, asynchronous (double-flop synchronized)
//   mcb_rst          active-high reset to the MCB
//   fb_enable        frame-buffer datapath enable
//   init_done        memory ready
//   init_fail        sticky failure flag, cleared only by reset
//   retry_cnt        calibration retries consumed
//   seq_state        FSM state code for debug
//                    (0 IDLE, 1 LOCK_WAIT, 2 RST_HOLD, 3 CALIB_WAIT, 4 READY, 5 FAIL)
//
// All outputs come straight from flops.
// Each output register is loaded on the same edge that moves the FSM into the state that
// output belongs to.
module mcb_init_sequencer #(
    parameter int unsigned LOCK_STABLE_CYCLES = 1024,
    parameter int unsigned RST_HOLD_CYCLES    = 64,
    parameter int unsigned CALIB_TIMEOUT      = 1048576,
    parameter int unsigned MAX_RETRY          = 3,
    parameter int unsigned CNT_WIDTH          = 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       bufpll_mcb_lock,
    input  logic       calib_done,
    output logic       mcb_rst,
    output logic       fb_enable,
    output logic       init_done,
    output logic       init_fail,
    output logic [1:0] retry_cnt,
    output logic [2:0] seq_state
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LOCK_WAIT  = 3'd1,
        RST_HOLD   = 3'd2,
        CALIB_WAIT = 3'd3,
        READY      = 3'd4,
        FAIL       = 3'd5
    } state_t;

    // Terminal counts. The counter runs from 0 and is compared for equality.
    localparam logic [CNT_WIDTH-1:0] LOCK_LAST   = CNT_WIDTH'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] HOLD_LAST   = CNT_WIDTH'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CALIB_LAST  = CNT_WIDTH'(CALIB_TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);
    localparam logic [1:0]           MAX_RETRY_C = 2'(MAX_RETRY);

    // Two-flop synchronizers.
    // Bit 0 carries the lock input and bit 1 carries calib_done.
    logic [1:0] meta_reg;
    logic [1:0] sync_reg;
    logic       lock_s;
    logic       calib_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_reg <= 2'b00;
            sync_reg <= 2'b00;
        end else begin
            meta_reg <= {calib_done, bufpll_mcb_lock};
            sync_reg <= meta_reg;
        end
    end

    assign lock_s  = sync_reg[0];
    assign calib_s = sync_reg[1];

    state_t                 state_reg;
    logic [CNT_WIDTH-1:0]   counter_reg;
    logic [1:0]             retry_cnt_reg;
    logic                   mcb_rst_reg;
    logic                   fb_enable_reg;
    logic                   init_done_reg;
    logic                   init_fail_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            counter_reg   <= '0;
            retry_cnt_reg <= 2'd0;
            mcb_rst_reg   <= 1'b1;
            fb_enable_reg <= 1'b0;
            init_done_reg <= 1'b0;
            init_fail_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    state_reg   <= LOCK_WAIT;
                    counter_reg <= '0;
                end

                LOCK_WAIT: begin
                    // Any low sample restarts the stability window.
                    if (!lock_s) begin
                        counter_reg <= '0;
                    end else if (counter_reg == LOCK_LAST) begin
                        state_reg   <= RST_HOLD;
                        counter_reg <= '0;
                    end else begin
                        counter_reg <= counter_reg + CNT_ONE;
                    end
                end

                RST_HOLD: begin
                    if (!lock_s) begin
                        state_reg   <= LOCK_WAIT;
                        counter_reg <= '0;
                    end else if (counter_reg == HOLD_LAST) begin
                        state_reg   <= CALIB_WAIT;
                        counter_reg <= '0;
                        mcb_rst_reg <= 1'b0;
                    end else begin
                        counter_reg <= counter_reg + CNT_ONE;
                    end
                end

                CALIB_WAIT: begin
                    // Lock loss is checked first.
                    // A calibration result obtained while the clock is gone cannot be trusted.
                    // Calibration done beats a coincident timeout.
                    if (!lock_s) begin
                        state_reg   <= LOCK_WAIT;
                        counter_reg <= '0;
                        mcb_rst_reg <= 1'b1;
                    end else if (calib_s) begin
                        state_reg     <= READY;
                        counter_reg   <= '0;
                        fb_enable_reg <= 1'b1;
                        init_done_reg <= 1'b1;
                    end else if (counter_reg == CALIB_LAST) begin
                        counter_reg <= '0;
                        mcb_rst_reg <= 1'b1;
                        if (retry_cnt_reg < MAX_RETRY_C) begin
                            retry_cnt_reg <= retry_cnt_reg + 2'd1;
                            state_reg     <= RST_HOLD;
                        end else begin
                            state_reg     <= FAIL;
                            init_fail_reg <= 1'b1;
                        end
                    end else begin
                        counter_reg <= counter_reg + CNT_ONE;
                    end
                end

                READY: begin
                    // Calibration done falling here is deliberately ignored.
                    if (!lock_s) begin
                        mcb_rst_reg   <= 1'b1;
                        fb_enable_reg <= 1'b0;
                        init_done_reg <= 1'b0;
                        counter_reg   <= '0;
`ifdef MCB_LOCK_LOSS_RECOVER_EN
                        state_reg     <= LOCK_WAIT;
                        retry_cnt_reg <= 2'd0;
`else
                        state_reg     <= FAIL;
                        init_fail_reg <= 1'b1;
`endif
                    end
                end

                FAIL: begin
                    // Sticky: only reset leaves this state.
                    mcb_rst_reg   <= 1'b1;
                    fb_enable_reg <= 1'b0;
                    init_done_reg <= 1'b0;
                    init_fail_reg <= 1'b1;
                end

                default: begin
                    // Unused encodings restart the sequence from IDLE.
                    state_reg     <= IDLE;
                    counter_reg   <= '0;
                    mcb_rst_reg   <= 1'b1;
                    fb_enable_reg <= 1'b0;
                    init_done_reg <= 1'b0;
                end
            endcase
        end
    end

    assign mcb_rst   = mcb_rst_reg;
    assign fb_enable = fb_enable_reg;
    assign init_done = init_done_reg;
    assign init_fail = init_fail_reg;
    assign retry_cnt = retry_cnt_reg;
    assign seq_state = state_reg;

endmodule

// File: tb/tb_mcb_init_sequencer.sv
// Directed testbench for mcb_init_sequencer.
// It uses small parameters: LOCK_STABLE_CYCLES=8, RST_HOLD_CYCLES=4, CALIB_TIMEOUT=16, MAX_RETRY=2.
// Inputs are driven 1 ns after the rising edge and outputs are sampled at the same point.
// Expected latencies, counted in rising edges from the moment an input is driven:
//   lock high -> mcb_rst low          : 2 + 8 + 4   = 14
//   calib_done high -> init_done high : 2 + 1       = 3
//   CALIB_WAIT entry -> timeout       : 16
//   retry reset pulse                 : 4
//   lock low in READY -> reaction     : 2 + 1       = 3
//   1-cycle glitch after 6 high       : 14 + 6 + 1  = 21
module tb_mcb_init_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       bufpll_mcb_lock = 1'b0;
    logic       calib_done = 1'b0;
    logic       mcb_rst;
    logic       fb_enable;
    logic       init_done;
    logic       init_fail;
    logic [1:0] retry_cnt;
    logic [2:0] seq_state;

    int check_cnt = 0;
    int pass_cnt  = 0;

    mcb_init_sequencer #(
        .LOCK_STABLE_CYCLES(8),
        .RST_HOLD_CYCLES   (4),
        .CALIB_TIMEOUT     (16),
        .MAX_RETRY         (2),
        .CNT_WIDTH         (24)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .bufpll_mcb_lock(bufpll_mcb_lock),
        .calib_done     (calib_done),
        .mcb_rst        (mcb_rst),
        .fb_enable      (fb_enable),
        .init_done      (init_done),
        .init_fail      (init_fail),
        .retry_cnt      (retry_cnt),
        .seq_state      (seq_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_cnt++;
        if (got !== exp) begin
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end else begin
            pass_cnt++;
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic pick(input int sel);
        case (sel)
            0:       return mcb_rst;
            1:       return init_done;
            default: return init_fail;
        endcase
    endfunction

    // Counts edges until the selected output reaches val, bounded by limit edges.
    // A run that hits the bound returns n = limit.
    // That value then mismatches the expected latency in the caller's check.
    task automatic wait_sig(input int sel, input logic val, input int limit, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (pick(sel) !== val && n < limit);
    endtask

    // Holds reset for two edges with the given inputs, then releases it.
    task automatic do_reset(input logic lock_v, input logic calib_v);
        reset = 1'b1;
        bufpll_mcb_lock = lock_v;
        calib_done = calib_v;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, ".mcb_rst"},   32'(mcb_rst),   32'd1);
        check({pfx, ".fb_enable"}, 32'(fb_enable), 32'd0);
        check({pfx, ".init_done"}, 32'(init_done), 32'd0);
        check({pfx, ".init_fail"}, 32'(init_fail), 32'd0);
        check({pfx, ".retry_cnt"}, 32'(retry_cnt), 32'd0);
        check({pfx, ".seq_state"}, 32'(seq_state), 32'd0);
    endtask

    int n;

    initial begin
        // ---------------- Nominal bring-up ----------------
        do_reset(1'b1, 1'b0);
        check_reset_values("rst");
        wait_sig(0, 1'b0, 100, n);
        check("nom.rst_release_lat", 32'(n), 32'd14);
        check("nom.state_calib", 32'(seq_state), 32'd3);
        repeat (5) step();
        check("nom.not_ready_yet", 32'(init_done), 32'd0);
        calib_done = 1'b1;
        wait_sig(1, 1'b1, 100, n);
        check("nom.ready_lat", 32'(n), 32'd3);
        check("nom.fb_enable", 32'(fb_enable), 32'd1);
        check("nom.mcb_rst", 32'(mcb_rst), 32'd0);
        check("nom.retry_cnt", 32'(retry_cnt), 32'd0);
        check("nom.state_ready", 32'(seq_state), 32'd4);
        calib_done = 1'b0;
        repeat (4) step();
        check("nom.calib_fall_ignored", 32'(seq_state), 32'd4);
        check("nom.still_done", 32'(init_done), 32'd1);

        // ---------------- Lock glitch ----------------
        do_reset(1'b0, 1'b0);
        repeat (3) step();
        check("glitch.lock_wait", 32'(seq_state), 32'd1);
        bufpll_mcb_lock = 1'b1;
        repeat (6) step();
        bufpll_mcb_lock = 1'b0;
        step();
        bufpll_mcb_lock = 1'b1;
        wait_sig(0, 1'b0, 100, n);
        check("glitch.rst_release_lat", 32'(n + 7), 32'd21);

        // ---------------- Retries then success ----------------
        do_reset(1'b1, 1'b0);
        wait_sig(0, 1'b0, 100, n);
        check("retry.first_release", 32'(n), 32'd14);
        for (int a = 1; a <= 2; a++) begin
            wait_sig(0, 1'b1, 100, n);
            check($sformatf("retry.timeout%0d", a), 32'(n), 32'd16);
            check($sformatf("retry.cnt%0d", a), 32'(retry_cnt), 32'(a));
            check($sformatf("retry.state_hold%0d", a), 32'(seq_state), 32'd2);
            wait_sig(0, 1'b0, 100, n);
            check($sformatf("retry.pulse%0d", a), 32'(n), 32'd4);
        end
        step();
        step();
        calib_done = 1'b1;
        wait_sig(1, 1'b1, 100, n);
        check("retry.ready_lat", 32'(n), 32'd3);
        check("retry.cnt_final", 32'(retry_cnt), 32'd2);
        check("retry.no_fail", 32'(init_fail), 32'd0);
        check("retry.state_ready", 32'(seq_state), 32'd4);

        // ---------------- Calibration exhausted ----------------
        do_reset(1'b1, 1'b0);
        wait_sig(0, 1'b0, 100, n);
        for (int a = 1; a <= 2; a++) begin
            wait_sig(0, 1'b1, 100, n);
            wait_sig(0, 1'b0, 100, n);
        end
        wait_sig(2, 1'b1, 100, n);
        check("exh.fail_lat", 32'(n), 32'd16);
        check("exh.state_fail", 32'(seq_state), 32'd5);
        check("exh.mcb_rst", 32'(mcb_rst), 32'd1);
        check("exh.retry_cnt", 32'(retry_cnt), 32'd2);
        check("exh.fb_enable", 32'(fb_enable), 32'd0);
        check("exh.init_done", 32'(init_done), 32'd0);
        calib_done = 1'b1;
        repeat (20) step();
        check("exh.sticky_fail", 32'(init_fail), 32'd1);
        check("exh.sticky_state", 32'(seq_state), 32'd5);
        do_reset(1'b1, 1'b0);
        check("exh.reset_clears", 32'(init_fail), 32'd0);

        // ---------------- Lock loss in READY ----------------
        do_reset(1'b1, 1'b0);
        wait_sig(0, 1'b0, 100, n);
        wait_sig(0, 1'b1, 100, n);
        wait_sig(0, 1'b0, 100, n);
        step();
        calib_done = 1'b1;
        wait_sig(1, 1'b1, 100, n);
        check("loss.ready_retry", 32'(retry_cnt), 32'd1);
        bufpll_mcb_lock = 1'b0;
        calib_done = 1'b0;
`ifdef MCB_LOCK_LOSS_RECOVER_EN
        wait_sig(1, 1'b0, 100, n);
        check("loss.drop_lat", 32'(n), 32'd3);
        check("loss.mcb_rst", 32'(mcb_rst), 32'd1);
        check("loss.fb_enable", 32'(fb_enable), 32'd0);
        check("loss.state_lock_wait", 32'(seq_state), 32'd1);
        check("loss.retry_cleared", 32'(retry_cnt), 32'd0);
        check("loss.no_fail", 32'(init_fail), 32'd0);
        repeat (3) step();
        bufpll_mcb_lock = 1'b1;
        wait_sig(0, 1'b0, 100, n);
        check("loss.reinit_release", 32'(n), 32'd14);
        step();
        calib_done = 1'b1;
        wait_sig(1, 1'b1, 100, n);
        check("loss.reinit_ready", 32'(n), 32'd3);
        check("loss.reinit_fb", 32'(fb_enable), 32'd1);
`else
        wait_sig(2, 1'b1, 100, n);
        check("loss.fail_lat", 32'(n), 32'd3);
        check("loss.state_fail", 32'(seq_state), 32'd5);
        check("loss.mcb_rst", 32'(mcb_rst), 32'd1);
        check("loss.init_done", 32'(init_done), 32'd0);
        check("loss.fb_enable", 32'(fb_enable), 32'd0);
`endif

        // ---------------- Reset mid-CALIB_WAIT ----------------
        do_reset(1'b1, 1'b0);
        wait_sig(0, 1'b0, 100, n);
        wait_sig(0, 1'b1, 100, n);
        wait_sig(0, 1'b0, 100, n);
        repeat (3) step();
        check("midrst.pre_retry", 32'(retry_cnt), 32'd1);
        check("midrst.pre_state", 32'(seq_state), 32'd3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_reset_values("midrst");
        wait_sig(0, 1'b0, 100, n);
        check("midrst.release_lat", 32'(n), 32'd14);
        step();
        calib_done = 1'b1;
        wait_sig(1, 1'b1, 100, n);
        check("midrst.ready_lat", 32'(n), 32'd3);
        check("midrst.retry_cnt", 32'(retry_cnt), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
